// File: rtl/micro_port_rx.sv
// Receiver for byte writes from the dash microcontroller. Bytes land in a staging
// file, which is copied to the active file (reg_flat) only on a frame boundary.
module micro_port_rx #(
  parameter int NUM_REGS    = 16,
  parameter int ADDR_W      = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic [7:0]            fpga_port_in,
  input  logic                  fpga_rsel,
  input  logic                  fpga_write,
  input  logic                  frame_start,
  output logic [NUM_REGS*8-1:0] reg_flat,
  output logic [ADDR_W-1:0]     addr_ptr,
  output logic                  dirty,
  output logic                  commit,
  output logic                  addr_err
);

  localparam int GUARD_W = $clog2(SYNC_STAGES + 2);
  localparam logic [GUARD_W-1:0] GUARD_LOAD = GUARD_W'(SYNC_STAGES + 1);
  localparam logic [8:0] NUM_REGS_LIM = 9'(NUM_REGS);

  // Each stage carries {write, rsel, data} so the three stay aligned.
  logic [SYNC_STAGES-1:0][9:0] sync_reg;
  logic                        prev_write_reg;
  logic [GUARD_W-1:0]          guard_reg;
  logic                        evt_next;
  logic                        evt_reg;
  logic                        evt_rsel_reg;
  logic [7:0]                  evt_data_reg;
  logic                        data_wr;
  logic                        addr_wr;
  logic                        addr_in_range;
  logic [NUM_REGS-1:0][7:0]    staging_reg;
  logic [NUM_REGS-1:0][7:0]    active_reg;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      sync_reg       <= '0;
      prev_write_reg <= 1'b0;
      guard_reg      <= GUARD_LOAD;
    end else begin
      sync_reg       <= {sync_reg[SYNC_STAGES-2:0], {fpga_write, fpga_rsel, fpga_port_in}};
      prev_write_reg <= sync_reg[SYNC_STAGES-1][9];
      if (guard_reg != '0) guard_reg <= guard_reg - 1'b1;
    end
  end

  // prev_write_reg keeps tracking during the guard window, so a strobe held
  // high across reset release never looks like a fresh rising edge.
  assign evt_next = (guard_reg == '0) && sync_reg[SYNC_STAGES-1][9] && !prev_write_reg;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      evt_reg      <= 1'b0;
      evt_rsel_reg <= 1'b0;
      evt_data_reg <= '0;
    end else begin
      evt_reg      <= evt_next;
      evt_rsel_reg <= sync_reg[SYNC_STAGES-1][8];
      evt_data_reg <= sync_reg[SYNC_STAGES-1][7:0];
    end
  end

  assign data_wr       = evt_reg && !evt_rsel_reg;
  assign addr_wr       = evt_reg && evt_rsel_reg;
  assign addr_in_range = {1'b0, evt_data_reg} < NUM_REGS_LIM;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      addr_ptr <= '0;
      addr_err <= 1'b0;
    end else if (data_wr) begin
      addr_ptr <= addr_ptr + ADDR_W'(1);
    end else if (addr_wr) begin
      if (addr_in_range) addr_ptr <= evt_data_reg[ADDR_W-1:0];
      else               addr_err <= 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      staging_reg <= '0;
    end else if (data_wr) begin
      staging_reg[addr_ptr] <= evt_data_reg;
    end
  end

  // A write coinciding with a commit lands in staging only; active takes the
  // pre-write copy and dirty stays set so the next frame picks the byte up.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      active_reg <= '0;
      dirty      <= 1'b0;
      commit     <= 1'b0;
    end else begin
      commit <= frame_start && dirty;
      if (frame_start && dirty) active_reg <= staging_reg;
      if (data_wr)          dirty <= 1'b1;
      else if (frame_start) dirty <= 1'b0;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_flat
      assign reg_flat[8*gi +: 8] = active_reg[gi];
    end
  endgenerate

endmodule
